buf_lookup_ctrl: RTL and testbench

- Request front-end sitting directly upstream of the 4-entry LFU replacement finder.
- Holds one tag per buffer (4 buffers) and accepts tag lookup requests on a valid/ready handshake.
- On a hit, reports the buffer number to the finder as a reference (ref_buf_numbr).
- On a miss, pulses new_buf_req, takes the finder's buf_num_replc as victim, installs the new tag there, reports any evicted tag, then returns the response.

---
 rtl/buf_lookup_ctrl.sv | 155 +++++++++++++++
 tb/tb_buf_lookup_ctrl.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/buf_lookup_ctrl.sv
// buf_lookup_ctrl: tag lookup front-end for the 4-entry LFU finder; a hit references the buffer, a miss fills the finder's victim.
// Define BUF_LOOKUP_STAT_EN to add saturating hit_cnt/miss_cnt outputs.
module buf_lookup_ctrl #(
    parameter int LEN   = 2,
    parameter int TAG_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [TAG_W-1:0] req_tag,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_hit,
    output logic [LEN-1:0]   rsp_buf_num,
    output logic             evict_valid,
    output logic [TAG_W-1:0] evict_tag,
    output logic             new_buf_req,
    output logic [LEN-1:0]   ref_buf_numbr,
    input  logic [LEN-1:0]   buf_num_replc
`ifdef BUF_LOOKUP_STAT_EN
    ,
    output logic [15:0]      hit_cnt,
    output logic [15:0]      miss_cnt
`endif
);
    localparam int NBUF = 1 << LEN;

    typedef enum logic [1:0] {IDLE, LOOKUP, FILL, RESP} state_e;

    state_e             state_q, state_d;
    logic [TAG_W-1:0]   tag_q [NBUF];
    logic [TAG_W-1:0]   tag_d [NBUF];
    logic [NBUF-1:0]    vld_q, vld_d;
    logic [TAG_W-1:0]   req_tag_q, req_tag_d;
    logic               rsp_hit_q, rsp_hit_d;
    logic [LEN-1:0]     rsp_buf_num_q, rsp_buf_num_d;
    logic               evict_valid_q, evict_valid_d;
    logic [TAG_W-1:0]   evict_tag_q, evict_tag_d;
    logic [LEN-1:0]     ref_q, ref_d;
    logic               hit;
    logic [LEN-1:0]     hit_idx;

    // Descending scan so the lowest matching index wins if duplicates ever exist.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = NBUF - 1; i >= 0; i--) begin
            if (vld_q[i] && tag_q[i] == req_tag_q) begin
                hit     = 1'b1;
                hit_idx = LEN'(i);
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        tag_d         = tag_q;
        vld_d         = vld_q;
        req_tag_d     = req_tag_q;
        rsp_hit_d     = rsp_hit_q;
        rsp_buf_num_d = rsp_buf_num_q;
        evict_valid_d = evict_valid_q;
        evict_tag_d   = evict_tag_q;
        ref_d         = ref_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    req_tag_d = req_tag;
                    state_d   = LOOKUP;
                end
            end
            LOOKUP: begin
                if (hit) begin
                    rsp_hit_d     = 1'b1;
                    rsp_buf_num_d = hit_idx;
                    evict_valid_d = 1'b0;
                    ref_d         = hit_idx;
                    state_d       = RESP;
                end else begin
                    state_d = FILL;
                end
            end
            FILL: begin
                evict_valid_d        = vld_q[buf_num_replc];
                evict_tag_d          = tag_q[buf_num_replc];
                tag_d[buf_num_replc] = req_tag_q;
                vld_d[buf_num_replc] = 1'b1;
                rsp_hit_d            = 1'b0;
                rsp_buf_num_d        = buf_num_replc;
                ref_d                = buf_num_replc;
                state_d              = RESP;
            end
            RESP: begin
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            tag_q         <= '{default: '0};
            vld_q         <= '0;
            req_tag_q     <= '0;
            rsp_hit_q     <= 1'b0;
            rsp_buf_num_q <= '0;
            evict_valid_q <= 1'b0;
            evict_tag_q   <= '0;
            ref_q         <= '0;
        end else begin
            state_q       <= state_d;
            tag_q         <= tag_d;
            vld_q         <= vld_d;
            req_tag_q     <= req_tag_d;
            rsp_hit_q     <= rsp_hit_d;
            rsp_buf_num_q <= rsp_buf_num_d;
            evict_valid_q <= evict_valid_d;
            evict_tag_q   <= evict_tag_d;
            ref_q         <= ref_d;
        end
    end

    assign req_ready     = state_q == IDLE;
    assign rsp_valid     = state_q == RESP;
    assign new_buf_req   = state_q == FILL;
    assign rsp_hit       = rsp_hit_q;
    assign rsp_buf_num   = rsp_buf_num_q;
    assign evict_valid   = evict_valid_q;
    assign evict_tag     = evict_tag_q;
    assign ref_buf_numbr = ref_q;

`ifdef BUF_LOOKUP_STAT_EN
    logic [15:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;

    always_comb begin
        hit_cnt_d  = hit_cnt_q + ((state_q == LOOKUP && hit && hit_cnt_q != 16'hFFFF) ? 16'd1 : 16'd0);
        miss_cnt_d = miss_cnt_q + ((state_q == FILL && miss_cnt_q != 16'hFFFF) ? 16'd1 : 16'd0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;
`endif
endmodule

// File: tb/tb_buf_lookup_ctrl.sv
// tb_buf_lookup_ctrl: directed bench for buf_lookup_ctrl; latencies count the accept cycle as cycle 0.
module tb_buf_lookup_ctrl;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_valid = 1'b0;
    logic       rsp_ready = 1'b0;
    logic [7:0] req_tag = 8'h00;
    logic [1:0] buf_num_replc = 2'd0;
    logic       req_ready, rsp_valid, rsp_hit, evict_valid, new_buf_req;
    logic [1:0] rsp_buf_num, ref_buf_numbr;
    logic [7:0] evict_tag;
`ifdef BUF_LOOKUP_STAT_EN
    logic [15:0] hit_cnt, miss_cnt;
`endif

    int total = 0;
    int bad = 0;

    int         lat, pulse_at, npulse;
    logic       r_hit, r_ev;
    logic [1:0] r_bn, r_ref;
    logic [7:0] r_et;

    always #5 clk = ~clk;

    buf_lookup_ctrl dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_tag       (req_tag),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_hit       (rsp_hit),
        .rsp_buf_num   (rsp_buf_num),
        .evict_valid   (evict_valid),
        .evict_tag     (evict_tag),
        .new_buf_req   (new_buf_req),
        .ref_buf_numbr (ref_buf_numbr),
        .buf_num_replc (buf_num_replc)
`ifdef BUF_LOOKUP_STAT_EN
        ,
        .hit_cnt       (hit_cnt),
        .miss_cnt      (miss_cnt)
`endif
    );

    task automatic reset_dut;
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        rst_n     = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Issue one request, hold the victim steady, capture the response, then accept it.
    task automatic do_req(input logic [7:0] tag, input logic [1:0] victim);
        buf_num_replc = victim;
        req_tag       = tag;
        req_valid     = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        req_tag  = 8'hEE;
        lat      = -1;
        pulse_at = -1;
        npulse   = 0;
        for (int k = 0; k < 10 && lat < 0; k++) begin
            if (new_buf_req) begin
                npulse++;
                pulse_at = k + 1;
            end
            if (rsp_valid) begin
                lat   = k + 1;
                r_hit = rsp_hit;
                r_bn  = rsp_buf_num;
                r_ev  = evict_valid;
                r_et  = evict_tag;
                r_ref = ref_buf_numbr;
            end else begin
                @(posedge clk);
                #1;
            end
        end
        if (lat < 0) begin
            total++;
            bad++;
            $display("FAIL rsp_timeout tag=%h no rsp_valid within 10 cycles", tag);
        end else begin
            rsp_ready = 1'b1;
            @(posedge clk);
            #1 rsp_ready = 1'b0;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        #2;
        total++;
        if ({req_ready, rsp_valid, rsp_hit, rsp_buf_num, evict_valid, evict_tag, new_buf_req, ref_buf_numbr} !== {1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 8'h00, 1'b0, 2'd0}) begin
            bad++;
            $display("FAIL reset_outputs got rdy=%b vld=%b hit=%b bn=%0d ev=%b et=%h nbr=%b ref=%0d exp rdy=1 rest=0",
                     req_ready, rsp_valid, rsp_hit, rsp_buf_num, evict_valid, evict_tag, new_buf_req, ref_buf_numbr);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_first_miss;
        do_req(8'hA5, 2'd0);
        total++;
        if (lat !== 3 || npulse !== 1 || pulse_at !== 2) begin
            bad++;
            $display("FAIL miss_timing got lat=%0d pulses=%0d pulse_at=%0d exp lat=3 pulses=1 pulse_at=2", lat, npulse, pulse_at);
        end
        total++;
        if ({r_hit, r_bn, r_ev, r_ref} !== {1'b0, 2'd0, 1'b0, 2'd0}) begin
            bad++;
            $display("FAIL miss_rsp got hit=%b bn=%0d ev=%b ref=%0d exp hit=0 bn=0 ev=0 ref=0", r_hit, r_bn, r_ev, r_ref);
        end
    endtask

    task automatic test_hit;
        do_req(8'hA5, 2'd3);
        total++;
        if (lat !== 2 || npulse !== 0) begin
            bad++;
            $display("FAIL hit_timing got lat=%0d pulses=%0d exp lat=2 pulses=0", lat, npulse);
        end
        total++;
        if ({r_hit, r_bn, r_ev, r_ref} !== {1'b1, 2'd0, 1'b0, 2'd0}) begin
            bad++;
            $display("FAIL hit_rsp got hit=%b bn=%0d ev=%b ref=%0d exp hit=1 bn=0 ev=0 ref=0", r_hit, r_bn, r_ev, r_ref);
        end
    endtask

    task automatic test_fill_evict;
        logic [7:0] tags [4] = '{8'h10, 8'h11, 8'h12, 8'h13};
        reset_dut();
        for (int n = 0; n < 4; n++) begin
            do_req(tags[n], 2'(n));
            total++;
            if ({r_hit, r_bn, r_ev, r_ref} !== {1'b0, 2'(n), 1'b0, 2'(n)} || lat !== 3) begin
                bad++;
                $display("FAIL fill_%0d got hit=%b bn=%0d ev=%b ref=%0d lat=%0d exp hit=0 bn=%0d ev=0 ref=%0d lat=3",
                         n, r_hit, r_bn, r_ev, r_ref, lat, n, n);
            end
        end
        do_req(8'h20, 2'd2);
        total++;
        if ({r_hit, r_bn, r_ev, r_et, r_ref} !== {1'b0, 2'd2, 1'b1, 8'h12, 2'd2}) begin
            bad++;
            $display("FAIL evict_12 got hit=%b bn=%0d ev=%b et=%h ref=%0d exp hit=0 bn=2 ev=1 et=12 ref=2", r_hit, r_bn, r_ev, r_et, r_ref);
        end
        do_req(8'h13, 2'd0);
        total++;
        if ({r_hit, r_bn, r_ref} !== {1'b1, 2'd3, 2'd3} || lat !== 2) begin
            bad++;
            $display("FAIL hit_13 got hit=%b bn=%0d ref=%0d lat=%0d exp hit=1 bn=3 ref=3 lat=2", r_hit, r_bn, r_ref, lat);
        end
        do_req(8'h12, 2'd1);
        total++;
        if ({r_hit, r_bn, r_ev, r_et} !== {1'b0, 2'd1, 1'b1, 8'h11}) begin
            bad++;
            $display("FAIL refill_12 got hit=%b bn=%0d ev=%b et=%h exp hit=0 bn=1 ev=1 et=11", r_hit, r_bn, r_ev, r_et);
        end
    endtask

    // Buffers now hold 0:10 1:12 2:20 3:13.
    task automatic test_backpressure;
        buf_num_replc = 2'd0;
        req_tag       = 8'h13;
        req_valid     = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        req_tag = 8'hEE;
        @(posedge clk);
        #1;
        for (int c = 0; c < 5; c++) begin
            total++;
            if ({rsp_valid, rsp_hit, rsp_buf_num, evict_valid, req_ready, new_buf_req} !== {1'b1, 1'b1, 2'd3, 1'b0, 1'b0, 1'b0}) begin
                bad++;
                $display("FAIL hold_%0d got vld=%b hit=%b bn=%0d ev=%b rdy=%b nbr=%b exp vld=1 hit=1 bn=3 ev=0 rdy=0 nbr=0",
                         c, rsp_valid, rsp_hit, rsp_buf_num, evict_valid, req_ready, new_buf_req);
            end
            if (c == 2) begin
                req_valid = 1'b1;
                req_tag   = 8'h55;
            end
            @(posedge clk);
            #1 req_valid = 1'b0;
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        total++;
        if ({rsp_valid, req_ready} !== 2'b01) begin
            bad++;
            $display("FAIL release got vld=%b rdy=%b exp vld=0 rdy=1", rsp_valid, req_ready);
        end
        do_req(8'h55, 2'd3);
        total++;
        if ({r_hit, r_bn, r_ev, r_et, r_ref} !== {1'b0, 2'd3, 1'b1, 8'h13, 2'd3}) begin
            bad++;
            $display("FAIL ignored_req got hit=%b bn=%0d ev=%b et=%h ref=%0d exp hit=0 bn=3 ev=1 et=13 ref=3", r_hit, r_bn, r_ev, r_et, r_ref);
        end
    endtask

    task automatic test_reset_fill;
        buf_num_replc = 2'd3;
        req_tag       = 8'h77;
        req_valid     = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(posedge clk);
        #1;
        total++;
        if (new_buf_req !== 1'b1) begin
            bad++;
            $display("FAIL fill_state got nbr=%b exp nbr=1", new_buf_req);
        end
        rst_n = 1'b0;
        #1;
        total++;
        if ({req_ready, rsp_valid, rsp_hit, rsp_buf_num, evict_valid, evict_tag, new_buf_req, ref_buf_numbr} !== {1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 8'h00, 1'b0, 2'd0}) begin
            bad++;
            $display("FAIL reset_in_fill got rdy=%b vld=%b hit=%b bn=%0d ev=%b et=%h nbr=%b ref=%0d exp rdy=1 rest=0",
                     req_ready, rsp_valid, rsp_hit, rsp_buf_num, evict_valid, evict_tag, new_buf_req, ref_buf_numbr);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        do_req(8'h77, 2'd1);
        total++;
        if ({r_hit, r_bn, r_ev} !== {1'b0, 2'd1, 1'b0} || lat !== 3) begin
            bad++;
            $display("FAIL aborted_tag got hit=%b bn=%0d ev=%b lat=%0d exp hit=0 bn=1 ev=0 lat=3", r_hit, r_bn, r_ev, lat);
        end
        do_req(8'h55, 2'd2);
        total++;
        if ({r_hit, r_bn, r_ev} !== {1'b0, 2'd2, 1'b0}) begin
            bad++;
            $display("FAIL lost_contents got hit=%b bn=%0d ev=%b exp hit=0 bn=2 ev=0", r_hit, r_bn, r_ev);
        end
    endtask

`ifdef BUF_LOOKUP_STAT_EN
    task automatic test_stats;
        reset_dut();
        do_req(8'h31, 2'd0);
        do_req(8'h32, 2'd1);
        do_req(8'h33, 2'd2);
        do_req(8'h31, 2'd3);
        do_req(8'h32, 2'd3);
        total++;
        if (miss_cnt !== 16'd3 || hit_cnt !== 16'd2) begin
            bad++;
            $display("FAIL stats got miss=%0d hit=%0d exp miss=3 hit=2", miss_cnt, hit_cnt);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_first_miss();
        test_hit();
        test_fill_evict();
        test_backpressure();
        test_reset_fill();
`ifdef BUF_LOOKUP_STAT_EN
        test_stats();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
